// File: rtl/i2c_bit_engine_if.sv
// Command handshake between the byte-level controller and the bit engine.
// The controller is the master; the engine is the slave.
interface i2c_bit_engine_if #(
    parameter int PRESCALE_W = 16
);
    logic [PRESCALE_W-1:0] prescale;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd;
    logic                  cmd_din;
    logic                  done;
    logic                  dout;
    logic                  al;

    modport master (
        output prescale, cmd_valid, cmd, cmd_din,
        input  cmd_ready, done, dout, al
    );

    modport slave (
        input  prescale, cmd_valid, cmd, cmd_din,
        output cmd_ready, done, dout, al
    );
endinterface

// File: rtl/i2c_bit_engine.sv
// Bit-level I2C master: one START/STOP/WRITE/READ per command, four
// quarter-bit phases each, with stretching, arbitration and busy tracking.
module i2c_bit_engine #(
    parameter int PRESCALE_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    i2c_bit_engine_if.slave cmd_if,
    output logic            busy,
    input  logic            scl_in,
    output logic            scl_out,
    output logic            scl_oen,
    input  logic            sda_in,
    output logic            sda_out,
    output logic            sda_oen
);
    typedef enum logic [2:0] {
        IDLE, PH_A, PH_B, PH_C, PH_D
    } state_t;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_READ  = 2'b11;

    state_t                state, state_n;
    logic [PRESCALE_W-1:0] pre_r, cnt;
    logic [1:0]            cmd_r, c_sel;
    logic                  din_r, d_sel;
    logic [1:0]            scl_sync, sda_sync;
    logic                  scl_s, sda_s, scl_q, sda_q;
    logic [1:0]            scl_age;
    logic [1:0]            lvl_n;
    logic                  accept, stall, phase_end, arb;

    assign scl_out = 1'b0;
    assign sda_out = 1'b0;
    assign scl_s   = scl_sync[1];
    assign sda_s   = sda_sync[1];

    assign cmd_if.cmd_ready = (state == IDLE);
    assign accept = cmd_if.cmd_valid && (state == IDLE);

    // Stretch is only trusted once the synchroniser has seen our release.
    assign stall = (state == PH_B) && !scl_s && (scl_age == 2'd2);
    assign phase_end = (state != IDLE) && !stall && (cnt == pre_r);

    assign arb = phase_end && !sda_s &&
        (((state == PH_B) && (cmd_r == C_START)) ||
         (((state == PH_B) || (state == PH_C)) &&
          (cmd_r == C_WRITE) && din_r));

    // Two-flop synchronisers plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    // Cycles since SCL was released, saturating at the sync latency.
    always_ff @(posedge clk) begin
        if (rst || !scl_oen) begin
            scl_age <= 2'd0;
        end else if (scl_age != 2'd2) begin
            scl_age <= scl_age + 2'd1;
        end
    end

    // Phase state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next phase and the line levels that phase drives, as {sda, scl}.
    always_comb begin
        state_n = state;
        c_sel   = accept ? cmd_if.cmd : cmd_r;
        d_sel   = accept ? cmd_if.cmd_din : din_r;
        lvl_n   = {sda_oen, scl_oen};
        unique case (state)
            IDLE: if (accept) state_n = PH_A;
            PH_A: if (phase_end) state_n = PH_B;
            PH_B: begin
                if (arb) state_n = IDLE;
                else if (phase_end) state_n = PH_C;
            end
            PH_C: begin
                if (arb) state_n = IDLE;
                else if (phase_end) state_n = PH_D;
            end
            PH_D: if (phase_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        unique case (state_n)
            PH_A: begin
                unique case (c_sel)
                    C_START: lvl_n = 2'b11;
                    C_STOP:  lvl_n = 2'b00;
                    C_WRITE: lvl_n = {d_sel, 1'b0};
                    default: lvl_n = 2'b10;
                endcase
            end
            PH_B, PH_C: begin
                unique case (c_sel)
                    C_START: lvl_n = (state_n == PH_B) ? 2'b11 : 2'b01;
                    C_STOP:  lvl_n = 2'b01;
                    C_WRITE: lvl_n = {d_sel, 1'b1};
                    default: lvl_n = 2'b11;
                endcase
            end
            PH_D: begin
                unique case (c_sel)
                    C_START: lvl_n = 2'b00;
                    C_STOP:  lvl_n = 2'b11;
                    C_WRITE: lvl_n = {d_sel, 1'b0};
                    default: lvl_n = 2'b10;
                endcase
            end
            default: lvl_n = {sda_oen, scl_oen};
        endcase
    end

    // Command latch, quarter counter, line drive and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r          <= '0;
            cmd_r          <= C_START;
            din_r          <= 1'b0;
            cnt            <= '0;
            sda_oen        <= 1'b1;
            scl_oen        <= 1'b1;
            cmd_if.done    <= 1'b0;
            cmd_if.al      <= 1'b0;
            cmd_if.dout    <= 1'b0;
        end else begin
            if (accept) begin
                pre_r <= cmd_if.prescale;
                cmd_r <= cmd_if.cmd;
                din_r <= cmd_if.cmd_din;
            end
            if ((state == IDLE) || phase_end) begin
                cnt <= '0;
            end else if (!stall) begin
                cnt <= cnt + 1'b1;
            end
            if (arb) begin
                {sda_oen, scl_oen} <= 2'b11;
            end else begin
                {sda_oen, scl_oen} <= lvl_n;
            end
            if ((state == PH_B) && phase_end && (cmd_r == C_READ)) begin
                cmd_if.dout <= sda_s;
            end
            cmd_if.done <= (state == PH_D) && phase_end;
            cmd_if.al   <= arb;
        end
    end

    // Bus busy from START/STOP conditions seen on the synchronised lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (scl_s && scl_q && sda_q && !sda_s) begin
            busy <= 1'b1;
        end else if (scl_s && scl_q && !sda_q && sda_s) begin
            busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_i2c_bit_engine.sv
// Self-checking bench for i2c_bit_engine: directed scenarios plus random
// command streams against a per-cycle phase-table model.
module tb_i2c_bit_engine;
    localparam logic [1:0] START = 2'b00;
    localparam logic [1:0] STOP  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] READ  = 2'b11;

    logic clk = 1'b0;
    logic rst;
    logic busy, scl_in, scl_out, scl_oen, sda_in, sda_out, sda_oen;
    logic stretch   = 1'b0;
    logic slave_low = 1'b0;
    logic force_low = 1'b0;
    logic m_busy    = 1'b0;
    logic m_dout    = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    i2c_bit_engine_if #(.PRESCALE_W(16)) bus ();

    i2c_bit_engine #(.PRESCALE_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_if  (bus),
        .busy    (busy),
        .scl_in  (scl_in),
        .scl_out (scl_out),
        .scl_oen (scl_oen),
        .sda_in  (sda_in),
        .sda_out (sda_out),
        .sda_oen (sda_oen)
    );

    // Open-drain pads: wired-AND of our release with the slave's pulls.
    assign scl_in = scl_oen & ~stretch;
    assign sda_in = sda_oen & ~slave_low & ~force_low;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {sda_oen, scl_oen} for phase ph (0..3 = A..D).
    function automatic logic [1:0] exp_lv(input logic [1:0] c,
                                          input logic d, input int ph);
        logic [1:0] t [4];
        case (c)
            START: t = '{2'b11, 2'b11, 2'b01, 2'b00};
            STOP:  t = '{2'b00, 2'b01, 2'b01, 2'b11};
            WRITE: t = '{{d, 1'b0}, {d, 1'b1}, {d, 1'b1}, {d, 1'b0}};
            default: t = '{2'b10, 2'b11, 2'b11, 2'b10};
        endcase
        return t[ph];
    endfunction

    // Called at a negedge with the engine idle; returns #1 after accept.
    task automatic issue(input logic [1:0] c, input logic d, input int pre);
        chk("ready", 32'(bus.cmd_ready), 32'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.cmd_din   = d;
        bus.prescale  = 16'(pre);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'($urandom);
        bus.cmd_din   = 1'($urandom);
        bus.prescale  = 16'($urandom);
    endtask

    // Full unstretched command with per-cycle line checks; ends at done.
    task automatic run_cmd(input logic [1:0] c, input logic d,
                           input int pre, input logic sbit);
        int p = pre + 1;
        issue(c, d, pre);
        slave_low = (c == READ) && !sbit;
        for (int k = 1; k <= 4 * p; k++) begin
            @(negedge clk);
            chk("lines", 32'({sda_oen, scl_oen}), 32'(exp_lv(c, d, (k - 1) / p)));
            chk("done_early", 32'(bus.done), 32'(0));
            chk("al_quiet", 32'(bus.al), 32'(0));
            if (c == START && k == 2 * p + 4)
                chk("busy_set", 32'(busy), 32'(1));
        end
        @(negedge clk);
        if (c == START) m_busy = 1'b1;
        if (c == STOP) m_busy = 1'b0;
        if (c == READ) m_dout = sbit;
        chk("done", 32'(bus.done), 32'(1));
        chk("al_at_done", 32'(bus.al), 32'(0));
        chk("dout", 32'(bus.dout), 32'(m_dout));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("idle_hold", 32'({sda_oen, scl_oen}), 32'(exp_lv(c, d, 3)));
        slave_low = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] byte_v;
        logic       sb;
        int         n;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd = START;
        bus.cmd_din = 1'b0;
        bus.prescale = '0;
        repeat (3) @(negedge clk);
        chk("rst_lines", 32'({sda_oen, scl_oen}), 32'(2'b11));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_al", 32'(bus.al), 32'(0));
        chk("rst_dout", 32'(bus.dout), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(bus.cmd_ready), 32'(1));
        rst = 1'b0;
        @(negedge clk);

        run_cmd(START, 1'b0, 4, 1'b1);

        byte_v = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            run_cmd(WRITE, byte_v[i], 2, 1'b1);
        end

        run_cmd(READ, 1'b0, 2, 1'b0);
        run_cmd(READ, 1'b0, 2, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom), 1'($urandom),
                    int'($urandom_range(5, 2)), 1'($urandom));
        end

        // Stretched READ: SCL held low 20 cycles from the start of B.
        sb = 1'($urandom);
        issue(READ, 1'b0, 3);
        slave_low = !sb;
        repeat (4) @(negedge clk);
        @(negedge clk);
        stretch = 1'b1;
        repeat (20) @(negedge clk);
        stretch = 1'b0;
        n = 25;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 80);
        chk("stretch_done", 32'(bus.done), 32'(1));
        chk("stretch_delay", 32'(n - 17 >= 20 && n - 17 <= 23), 32'(1));
        chk("stretch_dout", 32'(bus.dout), 32'(sb));
        slave_low = 1'b0;

        // Arbitration loss on a WRITE 1 with SDA pulled low from B.
        issue(WRITE, 1'b1, 2);
        repeat (3) @(negedge clk);
        @(negedge clk);
        force_low = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("al_early", 32'(bus.al), 32'(0));
        end
        @(negedge clk);
        chk("al_pulse", 32'(bus.al), 32'(1));
        chk("al_no_done", 32'(bus.done), 32'(0));
        chk("al_lines", 32'({sda_oen, scl_oen}), 32'(2'b11));
        chk("al_ready", 32'(bus.cmd_ready), 32'(1));
        @(negedge clk);
        chk("al_once", 32'(bus.al), 32'(0));
        chk("al_done2", 32'(bus.done), 32'(0));
        chk("al_ready2", 32'(bus.cmd_ready), 32'(1));
        force_low = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a WRITE.
        issue(WRITE, 1'($urandom), 3);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_lines", 32'({sda_oen, scl_oen}), 32'(2'b11));
        chk("mrst_ready", 32'(bus.cmd_ready), 32'(1));
        chk("mrst_done", 32'(bus.done), 32'(0));
        chk("mrst_al", 32'(bus.al), 32'(0));
        chk("mrst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        m_busy = 1'b0;
        m_dout = 1'b0;
        run_cmd(STOP, 1'b0, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
